// File: rtl/call_stack_ctrl.sv
// Call/return stack controller owning SP on the data memory PC/SP port (empty-descending stack).
// Latency: push write one cycle after acceptance; pop result (ret_valid) two cycles after acceptance.
// Backpressure: ready low while an operation is in flight; mem_busy stalls PUSH and POP_RD; requests seen while not ready are dropped.
module call_stack_ctrl #(
   parameter int unsigned STACK_TOP   = 399,
   parameter int unsigned STACK_DEPTH = 100,
   parameter int unsigned DEPTH_W     = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               call_req,
   input  logic [15:0]        call_pc,
   input  logic               ret_req,
   output logic               ready,
   output logic               ret_valid,
   output logic [15:0]        ret_pc,
   output logic               stack_overflow,
   output logic               stack_underflow,
   output logic [DEPTH_W-1:0] depth,
   input  logic               mem_busy,
   output logic [8:0]         sp_address,
   output logic [15:0]        pc_data,
   output logic               signal_pc_data_write,
   input  logic [15:0]        pc_read_data
);

   localparam logic [8:0]         SP_RESET  = 9'(STACK_TOP);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PUSH    = 2'd1,
      ST_POP_RD  = 2'd2,
      ST_POP_CAP = 2'd3
   } state_t;

   state_t      state;
   logic [8:0]  sp;
   logic [8:0]  sp_plus1;
   logic [15:0] pc_lat;

   // SP points at the next free slot, so the top entry lives at SP+1.
   assign sp_plus1   = sp + 9'd1;
   assign ready      = (state == ST_IDLE);
   assign pc_data    = pc_lat;
   assign sp_address = (state == ST_POP_RD || state == ST_POP_CAP) ? sp_plus1 : sp;

   // Write strobe is combinational so it yields to higher-priority ports in the same cycle
   // and drops immediately when reset forces the state back to IDLE.
   assign signal_pc_data_write = (state == ST_PUSH) && !mem_busy;

   // Main controller: request arbitration, SP/depth bookkeeping and registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         sp              <= SP_RESET;
         depth           <= '0;
         pc_lat          <= '0;
         ret_pc          <= '0;
         ret_valid       <= 1'b0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         ret_valid       <= 1'b0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A call always wins over a simultaneous ret; the ret is simply dropped.
               if (call_req) begin
                  if (depth < DEPTH_MAX) begin
                     pc_lat <= call_pc;
                     state  <= ST_PUSH;
                  end else begin
                     stack_overflow <= 1'b1;
                  end
               end else if (ret_req) begin
                  if (depth != '0) begin
                     state <= ST_POP_RD;
                  end else begin
                     stack_underflow <= 1'b1;
                  end
               end
            end
            ST_PUSH: begin
               if (!mem_busy) begin
                  sp    <= sp - 9'd1;
                  depth <= depth + DEPTH_ONE;
                  state <= ST_IDLE;
               end
            end
            ST_POP_RD: begin
               // Memory only registers a read on a cycle with no write port active.
               if (!mem_busy) begin
                  state <= ST_POP_CAP;
               end
            end
            ST_POP_CAP: begin
               ret_pc    <= pc_read_data;
               ret_valid <= 1'b1;
               sp        <= sp_plus1;
               depth     <= depth - DEPTH_ONE;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl with a behavioural data memory and a queue-based stack model.
// Latency: checks every cycle of each push/pop against the expected cycle-level behaviour.
// Backpressure: drives mem_busy stalls and stray requests while the controller is busy.
module tb_call_stack_ctrl;
   localparam int TOP   = 399;
   localparam int DEPTH = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        call_req;
   logic [15:0] call_pc;
   logic        ret_req;
   logic        ready;
   logic        ret_valid;
   logic [15:0] ret_pc;
   logic        stack_overflow;
   logic        stack_underflow;
   logic [6:0]  depth;
   logic        mem_busy;
   logic [8:0]  sp_address;
   logic [15:0] pc_data;
   logic        signal_pc_data_write;
   logic [15:0] pc_read_data;

   int checks = 0;
   int errors = 0;

   logic [15:0] model_q[$];
   logic [15:0] last_ret;
   logic [15:0] mem [0:TOP];
   logic [15:0] rd_q;

   call_stack_ctrl dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .call_req             (call_req),
      .call_pc              (call_pc),
      .ret_req              (ret_req),
      .ready                (ready),
      .ret_valid            (ret_valid),
      .ret_pc               (ret_pc),
      .stack_overflow       (stack_overflow),
      .stack_underflow      (stack_underflow),
      .depth                (depth),
      .mem_busy             (mem_busy),
      .sp_address           (sp_address),
      .pc_data              (pc_data),
      .signal_pc_data_write (signal_pc_data_write),
      .pc_read_data         (pc_read_data)
   );

   always #5 clk = ~clk;

   assign pc_read_data = rd_q;

   // Data memory port: writes on strobe, otherwise a registered read returning stored value + 1.
   always @(posedge clk) begin
      if (signal_pc_data_write) mem[sp_address] <= pc_data;
      else if (!mem_busy) rd_q <= mem[sp_address] + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_sp();
      return TOP - model_q.size();
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Push one value, stalling the write for nbusy cycles; with_ret also raises ret_req.
   task automatic do_call(input logic [15:0] pc, input int nbusy, input logic with_ret);
      chk("call_ready", 32'(ready), 1);
      call_req = 1'b1; call_pc = pc; ret_req = with_ret; mem_busy = 1'b0;
      step();
      call_req = 1'b0; ret_req = 1'b0;
      chk("call_rv_clear", 32'(ret_valid), 0);
      if (model_q.size() >= DEPTH) begin
         chk("ovf_pulse", 32'(stack_overflow), 1);
         chk("ovf_strobe", 32'(signal_pc_data_write), 0);
         chk("ovf_ready", 32'(ready), 1);
         chk("ovf_depth", 32'(depth), DEPTH);
         chk("ovf_sp", 32'(sp_address), exp_sp());
         step();
         chk("ovf_drop", 32'(stack_overflow), 0);
         chk("ovf_strobe2", 32'(signal_pc_data_write), 0);
      end else begin
         for (int i = 0; i < nbusy; i++) begin
            mem_busy = 1'b1;
            call_req = 1'($urandom_range(0, 1));
            ret_req  = 1'($urandom_range(0, 1));
            #1;
            chk("push_busy_strobe", 32'(signal_pc_data_write), 0);
            chk("push_busy_ready", 32'(ready), 0);
            step();
         end
         mem_busy = 1'b0;
         #1;
         chk("push_strobe", 32'(signal_pc_data_write), 1);
         chk("push_addr", 32'(sp_address), exp_sp());
         chk("push_data", 32'(pc_data), 32'(pc));
         chk("push_ready", 32'(ready), 0);
         step();
         call_req = 1'b0; ret_req = 1'b0;
         model_q.push_back(pc);
         chk("push_done_ready", 32'(ready), 1);
         chk("push_done_depth", 32'(depth), model_q.size());
         chk("push_done_sp", 32'(sp_address), exp_sp());
         chk("push_done_strobe", 32'(signal_pc_data_write), 0);
      end
   endtask

   // Pop one value, stalling the read for nbusy cycles.
   task automatic do_ret(input int nbusy);
      logic [31:0] addr;
      logic [15:0] exp_pc;
      chk("ret_ready", 32'(ready), 1);
      ret_req = 1'b1; call_req = 1'b0; mem_busy = 1'b0;
      step();
      ret_req = 1'b0;
      chk("ret_rv_clear", 32'(ret_valid), 0);
      if (model_q.size() == 0) begin
         chk("unf_pulse", 32'(stack_underflow), 1);
         chk("unf_ready", 32'(ready), 1);
         chk("unf_sp", 32'(sp_address), TOP);
         chk("unf_hold_pc", 32'(ret_pc), 32'(last_ret));
         step();
         chk("unf_drop", 32'(stack_underflow), 0);
         chk("unf_no_rv", 32'(ret_valid), 0);
      end else begin
         addr = exp_sp() + 1;
         for (int i = 0; i < nbusy; i++) begin
            mem_busy = 1'b1;
            call_req = 1'($urandom_range(0, 1));
            ret_req  = 1'($urandom_range(0, 1));
            #1;
            chk("pop_busy_addr", 32'(sp_address), addr);
            chk("pop_busy_strobe", 32'(signal_pc_data_write), 0);
            chk("pop_busy_ready", 32'(ready), 0);
            step();
         end
         mem_busy = 1'b0;
         #1;
         chk("pop_rd_addr", 32'(sp_address), addr);
         chk("pop_rd_ready", 32'(ready), 0);
         step();
         mem_busy = 1'($urandom_range(0, 1));
         #1;
         chk("pop_cap_addr", 32'(sp_address), addr);
         chk("pop_cap_rv", 32'(ret_valid), 0);
         chk("pop_cap_strobe", 32'(signal_pc_data_write), 0);
         step();
         call_req = 1'b0; ret_req = 1'b0; mem_busy = 1'b0;
         exp_pc   = model_q.pop_back() + 16'd1;
         last_ret = exp_pc;
         chk("pop_rv", 32'(ret_valid), 1);
         chk("pop_pc", 32'(ret_pc), 32'(exp_pc));
         chk("pop_ready", 32'(ready), 1);
         chk("pop_depth", 32'(depth), model_q.size());
         chk("pop_sp", 32'(sp_address), exp_sp());
      end
   endtask

   initial begin
      rst_n = 1'b0; call_req = 1'b0; call_pc = '0; ret_req = 1'b0; mem_busy = 1'b0;
      rd_q = '0; last_ret = '0;
      for (int a = 0; a <= TOP; a++) mem[a] = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_sp", 32'(sp_address), TOP);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_ret_pc", 32'(ret_pc), 0);
      chk("rst_rv", 32'(ret_valid), 0);
      chk("rst_ovf", 32'(stack_overflow), 0);
      chk("rst_unf", 32'(stack_underflow), 0);
      chk("rst_strobe", 32'(signal_pc_data_write), 0);
      rst_n = 1'b1;
      step();

      // Basic push then pop
      do_call(16'h0010, 0, 1'b0);
      chk("s1_sp", 32'(sp_address), 398);
      chk("s1_depth", 32'(depth), 1);
      do_ret(0);
      chk("s2_pc", 32'(ret_pc), 32'h0011);
      chk("s2_sp", 32'(sp_address), 399);

      // Underflow, fill to full, overflow, drain
      do_ret(0);
      for (int i = 0; i < DEPTH; i++) do_call(16'(16'h0100 + i), 0, 1'b0);
      chk("s3_full_depth", 32'(depth), 100);
      do_call(16'h0BAD, 0, 1'b0);
      chk("s3_ovf_depth", 32'(depth), 100);
      for (int i = 0; i < DEPTH; i++) do_ret(0);
      chk("s3_last_pc", 32'(ret_pc), 32'h0101);

      // Stalled push and pop
      do_call(16'h0AAA, 3, 1'b0);
      do_ret(2);
      chk("s4_pc", 32'(ret_pc), 32'h0AAB);

      // Simultaneous call/ret and nested LIFO order
      do_call(16'h0005, 0, 1'b0);
      do_call(16'h0007, 0, 1'b1);
      chk("s5_depth", 32'(depth), 2);
      do_call(16'h0020, 0, 1'b0);
      do_call(16'h0030, 0, 1'b0);
      do_ret(0);
      chk("s5_pc1", 32'(ret_pc), 32'h0031);
      do_ret(0);
      chk("s5_pc2", 32'(ret_pc), 32'h0021);
      do_ret(0);
      do_ret(0);

      // Randomized mix of calls and rets with stalls
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 99) < 55)
            do_call(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         else
            do_ret(int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a push before its write edge
      chk("s6_pre_ready", 32'(ready), 1);
      call_req = 1'b1; call_pc = 16'h0BEE; mem_busy = 1'b0;
      step();
      call_req = 1'b0;
      #1;
      chk("s6_strobe_before", 32'(signal_pc_data_write), 1);
      rst_n = 1'b0;
      #1;
      chk("s6_strobe_drop", 32'(signal_pc_data_write), 0);
      chk("s6_ready", 32'(ready), 1);
      chk("s6_sp", 32'(sp_address), TOP);
      chk("s6_depth", 32'(depth), 0);
      model_q.delete();
      last_ret = '0;
      step();
      rst_n = 1'b1;
      step();
      chk("s6_post_ready", 32'(ready), 1);
      chk("s6_post_depth", 32'(depth), 0);
      do_ret(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Initiator for the data memory's PC/SP port. It services CALL (push) and RET (pop) requests from the control unit. It owns the stack pointer and drives sp_address, pc_data and signal_pc_data_write. It reads return addresses back through pc_read_data, which the memory returns as stored value + 1. The stack is empty-descending at the top of the 400-word data memory, and the controller defers to the memory's higher-priority write ports via mem_busy.

Parameters:
STACK_TOP, 399, highest stack address and reset value of SP (9-bit)
STACK_DEPTH, 100, maximum stacked entries; STACK_TOP-STACK_DEPTH+1 must be >= 0
DEPTH_W, 7, width of depth output; must hold STACK_DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
call_req  input  1  push request; sampled only when ready=1
call_pc  input  16  PC value to push; captured with call_req
ret_req  input  1  pop request; sampled only when ready=1
ready  output  1  controller idle and accepting a request
ret_valid  output  1  one-cycle pulse, ret_pc valid
ret_pc  output  16  popped value as returned by memory (pushed PC + 1)
stack_overflow  output  1  one-cycle pulse, call rejected because the stack is full
stack_underflow  output  1  one-cycle pulse, ret rejected because the stack is empty
depth  output  DEPTH_W  current number of stacked entries
mem_busy  input  1  OR of mem_write, signal_acc_data_write, signal_crypto_data_write; port not available this cycle
sp_address  output  9  memory address for the PC/SP port
pc_data  output  16  data for a push write
signal_pc_data_write  output  1  push write strobe
pc_read_data  input  16  registered memory read: mem[sp_address]+1

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, SP=STACK_TOP, depth=0.
  - ret_pc=0; ret_valid=0; stack_overflow=0; stack_underflow=0.
  - signal_pc_data_write=0 immediately, with no clock required. Memory contents are untouched.
- States: IDLE, PUSH, POP_RD, POP_CAP. ready=1 only in IDLE.
- IDLE:
  - call_req=1 and depth<STACK_DEPTH: latch call_pc, go to PUSH.
  - call_req=1 and depth==STACK_DEPTH: stack_overflow=1 next cycle, stay in IDLE, SP unchanged.
  - ret_req=1 (call_req=0) and depth>0: go to POP_RD.
  - ret_req=1 (call_req=0) and depth==0: stack_underflow=1 next cycle, stay in IDLE.
  - call_req and ret_req both 1: the call is serviced, the ret is ignored, and the requester must re-present it.
- PUSH:
  - sp_address=SP and pc_data=latched PC.
  - signal_pc_data_write=~mem_busy (combinational).
  - On an edge with mem_busy=0: SP<=SP-1, depth<=depth+1, go to IDLE.
  - If mem_busy=1: hold the state and keep the strobe low.
- POP_RD:
  - sp_address=SP+1, strobe 0.
  - On an edge with mem_busy=0 the memory registers mem[SP+1]+1; go to POP_CAP.
  - If mem_busy=1: hold, because the memory performs no read while a write port is active.
- POP_CAP:
  - sp_address=SP+1, strobe 0.
  - At the edge: ret_pc<=pc_read_data, ret_valid<=1 (one cycle), SP<=SP+1, depth<=depth-1, go to IDLE.
- In IDLE, sp_address=SP and the strobe is 0.
- Latency with mem_busy=0:
  - Push: accepted at edge E0; write occurs at E1; ready again after E1.
  - Pop: accepted at E0; ret_valid is high in the cycle after E2, coincident with ready=1.
- Back-to-back: a new request may be accepted in the same cycle ret_valid is high.
- Arithmetic: SP is 9-bit. Underflow and overflow checks occur before any SP update, so SP never leaves [STACK_TOP-STACK_DEPTH, STACK_TOP].
- Requests presented while ready=0 are ignored and are not queued.
- Reset asserted mid-PUSH or mid-POP aborts the operation. A PUSH whose write edge has not yet occurred leaves memory unmodified.
- ret_pc holds its last value until the next pop.

Test Plan:
1. Reset, then call_req with call_pc=16'h0010, mem_busy=0 -> strobe=1 with sp_address=399 and pc_data=16'h0010 in the cycle after acceptance; depth=1, SP=398.
2. After scenario 1, ret_req -> sp_address=399 in POP_RD; ret_valid pulse with ret_pc=16'h0011; depth=0, SP=399.
3. From depth 0, ret_req -> stack_underflow pulses for 1 cycle, no ret_valid, SP stays 399. Push 100 values (16'h0100..16'h0163), then call_req -> stack_overflow pulse, depth=100, no write strobe.
4. Push 16'h0AAA with mem_busy=1 held for 3 cycles in PUSH -> strobe low for those 3 cycles, write occurs on the 4th cycle, total ready-low time 4 cycles. Pop with mem_busy=1 for 2 cycles in POP_RD -> ret_pc=16'h0AAB, arriving 2 cycles later.
5. call_req and ret_req both high at depth 1 -> push serviced, depth=2. Nested push 16'h0020 then 16'h0030, then two pops -> ret_pc=16'h0031, then 16'h0021 (LIFO order).
6. rst_n deasserted-low during PUSH before its write edge -> strobe drops immediately; after release ready=1, SP=399, depth=0; a subsequent pop -> underflow.
